inst_mem: RTL

INST_MEM -- requirements
Module: inst_mem

---
 rtl/inst_mem.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/inst_mem.sv
// ----------------------------------------------------------------------------
// inst_mem : instruction memory with a byte-serial program loader.
//
// The core fetches through a zero-latency combinational read port. A loader
// streams an image in as little-endian bytes; while a load is in progress the
// core is held in reset and every fetch returns NOP_INST. When the final byte
// is accepted the block returns to RUN, pulses ld_done_o and releases
// core_rstn_o in that same cycle, so the core restarts at PC 0 on the new image.
//
// Parameters
//   DEPTH     number of 32-bit words stored (at least 2)
//   NOP_INST  word returned for out-of-range fetches and during a load
//
// Ports
//   clk          single clock, rising edge
//   rstn         asynchronous active-low reset (memory contents are kept)
//   addr_i       fetch byte address; bits [1:0] ignored
//   inst_o       fetched instruction word (combinational)
//   ld_start_i   pulse that begins or restarts a load
//   ld_valid_i   load byte valid
//   ld_data_i    load byte
//   ld_last_i    marks the final byte of the image, sampled with ld_valid_i
//   ld_ready_o   high while loading (a byte is taken when valid && ready)
//   ld_done_o    one-cycle pulse after the load completes
//   ld_err_o     sticky: the image held more than DEPTH words
//   core_rstn_o  active-low reset to the core
//   chksum_o     modulo-256 sum of the loaded bytes
//
// Build option
//   INST_MEM_CHKSUM_EN  when defined, chksum_o accumulates every accepted byte;
//                       otherwise chksum_o is constant zero with no accumulator.
// ----------------------------------------------------------------------------
module inst_mem #(
  parameter int          DEPTH    = 4096,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] addr_i,
  output logic [31:0] inst_o,
  input  logic        ld_start_i,
  input  logic        ld_valid_i,
  input  logic [7:0]  ld_data_i,
  input  logic        ld_last_i,
  output logic        ld_ready_o,
  output logic        ld_done_o,
  output logic        ld_err_o,
  output logic        core_rstn_o,
  output logic [7:0]  chksum_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  // Fetch addresses at or beyond this byte address fall outside the memory.
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) * 33'd4;
  localparam logic [AW:0] WR_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0] WR_ONE     = (AW+1)'(1);

  logic [31:0]    mem [DEPTH];

  logic [0:0]     state_q, state_d;
  logic [AW:0]    wr_addr_q, wr_addr_d;
  logic [1:0]     byte_cnt_q, byte_cnt_d;
  logic           ld_done_q, ld_done_d;
  logic           ld_err_q, ld_err_d;
  logic           core_rstn_q, core_rstn_d;
  logic [31:0]    word_q, word_d;
  logic [31:0]    word_asm;
  logic           accept;
  logic           mem_we;
  logic [AW-1:0]  rd_idx;
`ifdef INST_MEM_CHKSUM_EN
  logic [7:0]     chksum_q, chksum_d;
`endif

  // Combinational fetch port
  assign rd_idx = addr_i[AW+1:2];
  always_comb begin
    inst_o = mem[rd_idx];
    if ((state_q == ST_LOAD) || ({1'b0, addr_i} >= ADDR_LIMIT)) begin
      inst_o = NOP_INST;
    end
  end

  assign accept = ld_valid_i && (state_q == ST_LOAD);

  // Word under assembly with the incoming byte dropped into its lane. Lanes
  // above the current one are still zero because word_q is cleared after each
  // write and on every start, which gives the zero fill for a short last word.
  always_comb begin
    word_asm = word_q;
    case (byte_cnt_q)
      2'd0:    word_asm[7:0]   = ld_data_i;
      2'd1:    word_asm[15:8]  = ld_data_i;
      2'd2:    word_asm[23:16] = ld_data_i;
      default: word_asm[31:24] = ld_data_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    byte_cnt_d = byte_cnt_q;
    ld_done_d  = 1'b0;
    ld_err_d   = ld_err_q;
    word_d     = word_q;
    mem_we     = 1'b0;
`ifdef INST_MEM_CHKSUM_EN
    chksum_d   = chksum_q;
`endif
    // A start pulse always wins, even over a byte offered in the same cycle;
    // memory already written is left as it is.
    if (ld_start_i) begin
      state_d    = ST_LOAD;
      wr_addr_d  = '0;
      byte_cnt_d = '0;
      ld_err_d   = 1'b0;
      word_d     = '0;
`ifdef INST_MEM_CHKSUM_EN
      chksum_d   = '0;
`endif
    end else if (accept) begin
`ifdef INST_MEM_CHKSUM_EN
      chksum_d = chksum_q + ld_data_i;
`endif
      if ((byte_cnt_q == 2'd3) || ld_last_i) begin
        word_d     = '0;
        byte_cnt_d = '0;
        // Once the memory is full further words are dropped and flagged.
        if (wr_addr_q == WR_FULL) begin
          ld_err_d = 1'b1;
        end else begin
          mem_we    = 1'b1;
          wr_addr_d = wr_addr_q + WR_ONE;
        end
      end else begin
        word_d     = word_asm;
        byte_cnt_d = byte_cnt_q + 2'd1;
      end
      if (ld_last_i) begin
        state_d   = ST_RUN;
        ld_done_d = 1'b1;
      end
    end
    // Registered so the core comes out of reset together with ld_done_o.
    core_rstn_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_RUN;
      wr_addr_q   <= '0;
      byte_cnt_q  <= '0;
      ld_done_q   <= 1'b0;
      ld_err_q    <= 1'b0;
      core_rstn_q <= 1'b0;
`ifdef INST_MEM_CHKSUM_EN
      chksum_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      byte_cnt_q  <= byte_cnt_d;
      ld_done_q   <= ld_done_d;
      ld_err_q    <= ld_err_d;
      core_rstn_q <= core_rstn_d;
`ifdef INST_MEM_CHKSUM_EN
      chksum_q    <= chksum_d;
`endif
    end
  end

  // Storage and the assembly register are not reset: a reset must not
  // disturb a loaded image, and a new load always clears word_q on start.
  always_ff @(posedge clk) begin
    word_q <= word_d;
    if (mem_we) begin
      mem[wr_addr_q[AW-1:0]] <= word_asm;
    end
  end

  assign ld_ready_o  = (state_q == ST_LOAD);
  assign ld_done_o   = ld_done_q;
  assign ld_err_o    = ld_err_q;
  assign core_rstn_o = core_rstn_q;
`ifdef INST_MEM_CHKSUM_EN
  assign chksum_o    = chksum_q;
`else
  assign chksum_o    = 8'h00;
`endif

endmodule
